// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store queue sitting between dispatch/AGU and an
// 8-bit single-cycle data memory.
//
// Loads issue to memory as soon as they reach the head of the queue. The
// result is captured into a CDB register and held until the arbiter accepts
// it. Stores wait at the head until the ROB commits them, and are then written
// to memory in the commit cycle.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   disp_*               dispatch handshake and the op payload
//                        (type, tag, address, store data)
//   commit_store         ROB commits the oldest store
//   flush                discard every queued op
//   cdb_*                load result broadcast (valid/ready handshake)
//   mem_*                direct drive of the memory pins, plus its
//                        combinational read data
//   count                number of occupied entries
//   commit_err           sticky flag: commit_store arrived with no store
//                        at the head
module lsu_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic                     disp_is_store,
  input  logic [TAG_W-1:0]         disp_tag,
  input  logic [7:0]               disp_addr,
  input  logic [7:0]               disp_data,
  input  logic                     commit_store,
  input  logic                     flush,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [7:0]               cdb_data,
  input  logic                     cdb_ready,
  output logic [7:0]               mem_addr,
  output logic [7:0]               mem_data_in,
  output logic                     mem_enable,
  output logic                     mem_wr,
  input  logic [7:0]               mem_data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     commit_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] LRESP = 1'b1;

  // Entry storage. Not reset: an entry is only read while it is occupied.
  logic             ent_store [DEPTH];
  logic [TAG_W-1:0] ent_tag   [DEPTH];
  logic [7:0]       ent_addr  [DEPTH];
  logic [7:0]       ent_data  [DEPTH];

  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic [0:0]       state_reg;
  logic [TAG_W-1:0] cdb_tag_reg;
  logic [7:0]       cdb_data_reg;
  logic             commit_err_reg;

  logic             full;
  logic             head_ok;
  logic             head_is_store;
  logic             issue_load;
  logic             issue_store;
  logic             push;
  logic             pop;

  assign full          = (count_reg == CW'(DEPTH));
  assign head_is_store = ent_store[head_reg];
  // The head may only issue from IDLE; in LRESP a load result is still
  // waiting for the CDB.
  assign head_ok       = (state_reg == IDLE) && (count_reg != '0);
  assign issue_load    = head_ok && !head_is_store;
  assign issue_store   = head_ok && head_is_store && commit_store;

  // A full queue refuses dispatch even when a pop happens in the same cycle,
  // which keeps disp_ready a pure function of registered state.
  assign push = disp_valid && !full && !flush;
  assign pop  = issue_load || issue_store;

  assign disp_ready = !full;
  assign cdb_valid  = (state_reg == LRESP);
  assign cdb_tag    = cdb_tag_reg;
  assign cdb_data   = cdb_data_reg;
  assign count      = count_reg;
  assign commit_err = commit_err_reg;

  // The memory pins are driven only while an access is issued, and are zero
  // otherwise, so a read and a write can never overlap.
  always_comb begin
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = 8'h00;
    mem_data_in = 8'h00;
    if (issue_load) begin
      mem_enable = 1'b1;
      mem_addr   = ent_addr[head_reg];
    end else if (issue_store) begin
      mem_enable  = 1'b1;
      mem_wr      = 1'b1;
      mem_addr    = ent_addr[head_reg];
      mem_data_in = ent_data[head_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ent_store[tail_reg] <= disp_is_store;
      ent_tag[tail_reg]   <= disp_tag;
      ent_addr[tail_reg]  <= disp_addr;
      ent_data[tail_reg]  <= disp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      state_reg      <= IDLE;
      cdb_tag_reg    <= '0;
      cdb_data_reg   <= '0;
      commit_err_reg <= 1'b0;
    end else begin
      // An illegal commit is ignored and only raises the sticky flag.
      if (commit_store && !(head_ok && head_is_store))
        commit_err_reg <= 1'b1;

      if (flush) begin
        // A store committed in this cycle has already been written, because
        // the memory samples at this same edge. A load issued in this cycle
        // is dropped.
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
        state_reg <= IDLE;
      end else begin
        // Pointers wrap on their own because DEPTH is a power of two.
        if (push) tail_reg <= tail_reg + 1'b1;
        if (pop)  head_reg <= head_reg + 1'b1;

        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase

        case (state_reg)
          IDLE: begin
            if (issue_load) begin
              cdb_tag_reg  <= ent_tag[head_reg];
              cdb_data_reg <= mem_data_out;
              state_reg    <= LRESP;
            end
          end
          LRESP: begin
            if (cdb_ready) state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu_queue.sv
// tb_lsu_queue: directed self-checking bench for lsu_queue (DEPTH=4, TAG_W=4).
// It contains a 256-byte behavioural memory that is attached to the mem_* pins.
module tb_lsu_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       disp_valid;
  logic       disp_ready;
  logic       disp_is_store;
  logic [3:0] disp_tag;
  logic [7:0] disp_addr;
  logic [7:0] disp_data;
  logic       commit_store;
  logic       flush;
  logic       cdb_valid;
  logic [3:0] cdb_tag;
  logic [7:0] cdb_data;
  logic       cdb_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_enable;
  logic       mem_wr;
  logic [7:0] mem_data_out;
  logic [2:0] count;
  logic       commit_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_model [256];

  always #5 clk = ~clk;

  lsu_queue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_is_store(disp_is_store),
    .disp_tag     (disp_tag),
    .disp_addr    (disp_addr),
    .disp_data    (disp_data),
    .commit_store (commit_store),
    .flush        (flush),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_ready    (cdb_ready),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_enable   (mem_enable),
    .mem_wr       (mem_wr),
    .mem_data_out (mem_data_out),
    .count        (count),
    .commit_err   (commit_err)
  );

  assign mem_data_out = mem_model[mem_addr];

  always @(posedge clk) begin
    if (mem_enable && mem_wr) mem_model[mem_addr] <= mem_data_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic st, input logic [3:0] tg, input logic [7:0] ad, input logic [7:0] dt);
    disp_valid    = 1'b1;
    disp_is_store = st;
    disp_tag      = tg;
    disp_addr     = ad;
    disp_data     = dt;
  endtask

  // Wait, with a cycle bound, for a CDB result; check it, then let it hand
  // shake (cdb_ready must already be high).
  task automatic wait_cdb(input logic [3:0] etag, input logic [7:0] edata);
    int n = 0;
    while (!cdb_valid && n < 10) begin
      tick();
      n++;
    end
    check("cdb_seen", 32'(cdb_valid), 1);
    check("cdb_tag", 32'(cdb_tag), 32'(etag));
    check("cdb_data", 32'(cdb_data), 32'(edata));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    rst = 1'b1; disp_valid = 1'b0; disp_is_store = 1'b0; disp_tag = '0;
    disp_addr = '0; disp_data = '0; commit_store = 1'b0; flush = 1'b0;
    cdb_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(disp_ready), 1);
    check("rst_cdb_valid", 32'(cdb_valid), 0);
    check("rst_mem_en", 32'(mem_enable), 0);
    check("rst_err", 32'(commit_err), 0);

    // Store tag1 to 0x10 with data 0xAB, committed in the following cycle.
    offer(1'b1, 4'd1, 8'h10, 8'hAB);
    #1 check("st_wait_mem_en", 32'(mem_enable), 0);
    tick();
    disp_valid = 1'b0; commit_store = 1'b1;
    #1;
    check("st_count1", 32'(count), 1);
    check("st_mem_en", 32'(mem_enable), 1);
    check("st_mem_wr", 32'(mem_wr), 1);
    check("st_mem_addr", 32'(mem_addr), 32'h10);
    check("st_mem_din", 32'(mem_data_in), 32'hAB);
    tick();
    commit_store = 1'b0;
    #1;
    check("st_count0", 32'(count), 0);
    check("st_mem_en_off", 32'(mem_enable), 0);
    check("st_written", 32'(mem_model[8'h10]), 32'hAB);

    // Load tag2 from 0x10: result on the CDB 2 cycles later, for exactly 1 cycle.
    cdb_ready = 1'b1;
    offer(1'b0, 4'd2, 8'h10, 8'h00);
    tick();
    disp_valid = 1'b0;
    #1;
    check("ld_mem_en", 32'(mem_enable), 1);
    check("ld_mem_wr", 32'(mem_wr), 0);
    check("ld_mem_addr", 32'(mem_addr), 32'h10);
    check("ld_cdb_early", 32'(cdb_valid), 0);
    tick();
    check("ld_cdb_valid", 32'(cdb_valid), 1);
    check("ld_cdb_tag", 32'(cdb_tag), 2);
    check("ld_cdb_data", 32'(cdb_data), 32'hAB);
    tick();
    check("ld_cdb_1cyc", 32'(cdb_valid), 0);

    // Load tag3 held by cdb_ready=0 for 3 cycles, with a store queued behind it.
    cdb_ready = 1'b0;
    offer(1'b0, 4'd3, 8'h10, 8'h00);
    tick();
    offer(1'b1, 4'd4, 8'h20, 8'h55);
    #1 check("hold_issue", 32'(mem_enable), 1);
    tick();
    disp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) cdb_ready = 1'b1;
      #1;
      check("hold_valid", 32'(cdb_valid), 1);
      check("hold_tag", 32'(cdb_tag), 3);
      check("hold_data", 32'(cdb_data), 32'hAB);
      check("hold_no_mem", 32'(mem_enable), 0);
      check("hold_count", 32'(count), 1);
      tick();
    end
    #1;
    check("hold_released", 32'(cdb_valid), 0);
    check("st_no_commit_mem", 32'(mem_enable), 0);
    check("hold_count_after", 32'(count), 1);

    // Flush the uncommitted store; the dispatch offered in the flush cycle is dropped.
    flush = 1'b1;
    offer(1'b0, 4'd15, 8'h10, 8'h00);
    tick();
    flush = 1'b0; disp_valid = 1'b0;
    #1;
    check("flush_count", 32'(count), 0);
    check("flush_cdb", 32'(cdb_valid), 0);
    check("flush_mem_en", 32'(mem_enable), 0);

    // Fill the queue behind an uncommitted store, then commit it and wrap the tail.
    offer(1'b1, 4'd5, 8'h30, 8'h11); tick();
    offer(1'b0, 4'd6, 8'h10, 8'h00); tick();
    offer(1'b0, 4'd7, 8'h20, 8'h00); tick();
    offer(1'b0, 4'd8, 8'h10, 8'h00); tick();
    offer(1'b0, 4'd9, 8'h30, 8'h00);
    #1;
    check("full_count", 32'(count), 4);
    check("full_ready", 32'(disp_ready), 0);
    tick();
    check("full_no_accept", 32'(count), 4);
    disp_valid = 1'b0; commit_store = 1'b1;
    #1;
    check("full_commit_ready", 32'(disp_ready), 0);
    check("full_commit_wr", 32'(mem_wr), 1);
    check("full_commit_addr", 32'(mem_addr), 32'h30);
    check("full_commit_din", 32'(mem_data_in), 32'h11);
    tick();
    commit_store = 1'b0;
    #1;
    check("after_commit_count", 32'(count), 3);
    check("after_commit_ready", 32'(disp_ready), 1);
    check("after_commit_mem", 32'(mem_model[8'h30]), 32'h11);
    cdb_ready = 1'b1;
    offer(1'b0, 4'd9, 8'h30, 8'h00);
    #1;
    check("wrap_issue_en", 32'(mem_enable), 1);
    check("wrap_issue_addr", 32'(mem_addr), 32'h10);
    tick();
    disp_valid = 1'b0;
    #1 check("push_pop_count", 32'(count), 3);
    wait_cdb(4'd6, 8'hAB);
    wait_cdb(4'd7, 8'h00);
    wait_cdb(4'd8, 8'hAB);
    wait_cdb(4'd9, 8'h11);
    check("drained_count", 32'(count), 0);

    // Two stores queued; flush together with a commit writes only the first one.
    offer(1'b1, 4'd1, 8'h40, 8'h77); tick();
    offer(1'b1, 4'd2, 8'h41, 8'h88); tick();
    disp_valid = 1'b0; flush = 1'b1; commit_store = 1'b1;
    #1;
    check("fc_wr", 32'(mem_wr), 1);
    check("fc_addr", 32'(mem_addr), 32'h40);
    check("fc_din", 32'(mem_data_in), 32'h77);
    tick();
    flush = 1'b0; commit_store = 1'b0;
    #1;
    check("fc_count", 32'(count), 0);
    check("fc_first_written", 32'(mem_model[8'h40]), 32'h77);
    check("fc_no_err", 32'(commit_err), 0);
    repeat (2) begin
      check("fc_idle_mem", 32'(mem_enable), 0);
      tick();
    end
    check("fc_second_not_written", 32'(mem_model[8'h41]), 0);

    // A load issued in the flush cycle produces no CDB result.
    offer(1'b0, 4'd3, 8'h40, 8'h00);
    tick();
    disp_valid = 1'b0; flush = 1'b1;
    #1 check("fl_load_issued", 32'(mem_enable), 1);
    tick();
    flush = 1'b0;
    #1;
    check("fl_load_no_cdb", 32'(cdb_valid), 0);
    check("fl_load_count", 32'(count), 0);
    tick();
    check("fl_load_no_cdb2", 32'(cdb_valid), 0);

    // commit_store with an empty queue: ignored, and sets the sticky error flag.
    commit_store = 1'b1;
    #1;
    check("cerr_no_mem", 32'(mem_enable), 0);
    check("cerr_before", 32'(commit_err), 0);
    tick();
    commit_store = 1'b0;
    #1 check("cerr_set", 32'(commit_err), 1);
    repeat (3) tick();
    check("cerr_sticky", 32'(commit_err), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("cerr_cleared", 32'(commit_err), 0);
    check("cerr_rst_count", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
